// File: rtl/cpu_mul_pkg.sv
// Shared types and constants for the execute-side pipelined multiplier.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

package cpu_mul_pkg;

   localparam int MUL_REG_W    = `REG_WIDTH;
   localparam int MUL_HALF_W   = MUL_REG_W / 2;
   localparam int MUL_NUM_REGS = `NUM_REGS;
   localparam int MUL_ID_W     = $clog2(MUL_NUM_REGS);
   localparam int MUL_STAGES   = 4;

   // acc carries lo*lo (later the full low-half sum); pp_* are truncated cross terms.
   typedef struct packed {
      logic                  valid;
      logic [MUL_ID_W-1:0]   rd_id;
      logic [MUL_REG_W-1:0]  acc;
      logic [MUL_HALF_W-1:0] pp_lh;
      logic [MUL_HALF_W-1:0] pp_hl;
   } mul_slot_t;

endpackage

// File: rtl/cpu_mul_pp.sv
// Combinational unsigned partial-product multiplier; result truncated/extended to OUT_W.
module cpu_mul_pp #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  a,
   input  logic [IN_W-1:0]  b,
   output logic [OUT_W-1:0] p
);

   logic [OUT_W-1:0] a_ext;
   logic [OUT_W-1:0] b_ext;

   assign a_ext = OUT_W'(a);
   assign b_ext = OUT_W'(b);
   assign p     = a_ext * b_ext;

endmodule

// File: rtl/cpu_mul_pipeline.sv
// Fixed-latency (STAGES cycles) low-half multiplier with global-stall backpressure,
// flush, and a pending-destination mask for decode hazard detection.
module cpu_mul_pipeline
   import cpu_mul_pkg::*;
#(
   parameter int REG_WIDTH = `REG_WIDTH,
   parameter int NUM_REGS  = `NUM_REGS,
   parameter int STAGES    = MUL_STAGES
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [$clog2(NUM_REGS)-1:0] in_rd_id,
   input  logic [REG_WIDTH-1:0]        in_ra,
   input  logic [REG_WIDTH-1:0]        in_rb,
   output logic                        in_ready,
   input  logic                        flush,
   output logic                        wb_valid,
   output logic [$clog2(NUM_REGS)-1:0] wb_rd_id,
   output logic [REG_WIDTH-1:0]        wb_data,
   input  logic                        wb_ready,
   output logic [NUM_REGS-1:0]         pending_mask
);

   localparam int H = REG_WIDTH / 2;

   mul_slot_t slots [STAGES];
   mul_slot_t nxt   [STAGES];

   logic [REG_WIDTH-1:0] pp_ll;
   logic [H-1:0]         pp_lh;
   logic [H-1:0]         pp_hl;
   logic                 adv;

   // hi*hi only affects bits >= REG_WIDTH, so it is never built.
   cpu_mul_pp #(.IN_W(H), .OUT_W(REG_WIDTH)) u_pp_ll (
      .a (in_ra[H-1:0]),
      .b (in_rb[H-1:0]),
      .p (pp_ll)
   );

   cpu_mul_pp #(.IN_W(H), .OUT_W(H)) u_pp_lh (
      .a (in_ra[H-1:0]),
      .b (in_rb[REG_WIDTH-1:H]),
      .p (pp_lh)
   );

   cpu_mul_pp #(.IN_W(H), .OUT_W(H)) u_pp_hl (
      .a (in_ra[REG_WIDTH-1:H]),
      .b (in_rb[H-1:0]),
      .p (pp_hl)
   );

   assign adv      = !(slots[STAGES-1].valid && !wb_ready);
   assign in_ready = adv;

   always_comb begin
      nxt[0]       = '0;
      nxt[0].valid = in_valid;
      nxt[0].rd_id = in_rd_id;
      nxt[0].acc   = pp_ll;
      nxt[0].pp_lh = pp_lh;
      nxt[0].pp_hl = pp_hl;

      // Cross terms land in the upper half; their carry-out is beyond the low half.
      nxt[1]       = slots[0];
      nxt[1].acc   = slots[0].acc + {slots[0].pp_lh + slots[0].pp_hl, {H{1'b0}}};
      nxt[1].pp_lh = '0;
      nxt[1].pp_hl = '0;

      for (int k = 2; k < STAGES; k++) begin
         nxt[k] = slots[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            slots[k] <= '0;
         end
      end else if (flush) begin
         for (int k = 0; k < STAGES; k++) begin
            slots[k].valid <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            slots[k] <= nxt[k];
         end
      end
   end

   assign wb_valid = slots[STAGES-1].valid;
   assign wb_rd_id = slots[STAGES-1].rd_id;
   assign wb_data  = slots[STAGES-1].acc;

   always_comb begin
      pending_mask = '0;
      for (int k = 0; k < STAGES; k++) begin
         if (slots[k].valid) begin
            pending_mask[slots[k].rd_id] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_mul_pipeline.sv
// Directed self-checking bench for cpu_mul_pipeline (default 32-bit, 32 regs, 4 stages).
module tb_cpu_mul_pipeline;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [4:0]  in_rd_id;
   logic [31:0] in_ra;
   logic [31:0] in_rb;
   logic        in_ready;
   logic        flush;
   logic        wb_valid;
   logic [4:0]  wb_rd_id;
   logic [31:0] wb_data;
   logic        wb_ready;
   logic [31:0] pending_mask;

   int total = 0;
   int bad   = 0;

   logic [31:0] qa   [16];
   logic [31:0] qb   [16];
   logic [4:0]  qrd  [16];
   logic [31:0] qexp [16];

   cpu_mul_pipeline #(.REG_WIDTH(32), .NUM_REGS(32), .STAGES(S)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_rd_id     (in_rd_id),
      .in_ra        (in_ra),
      .in_rb        (in_rb),
      .in_ready     (in_ready),
      .flush        (flush),
      .wb_valid     (wb_valid),
      .wb_rd_id     (wb_rd_id),
      .wb_data      (wb_data),
      .wb_ready     (wb_ready),
      .pending_mask (pending_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] e);
      qa[i]   = a;
      qb[i]   = b;
      qrd[i]  = rd;
      qexp[i] = e;
   endtask

   task automatic drive_op(input int i);
      in_valid = 1'b1;
      in_ra    = qa[i];
      in_rb    = qb[i];
      in_rd_id = qrd[i];
   endtask

   // Issues n queued ops back-to-back with wb_ready=1 and checks exact-cycle results.
   task automatic run_seq(input string name, input int n);
      logic [31:0] em;
      int idx;
      for (int t = 0; t < n + S; t++) begin
         if (t < n) drive_op(t);
         else       in_valid = 1'b0;
         step();
         idx = t - (S - 1);
         em  = '0;
         for (int j = 0; j < n; j++) begin
            if (j <= t && j >= t - (S - 1)) em[qrd[j]] = 1'b1;
         end
         chk($sformatf("%s_mask_t%0d", name, t), pending_mask, em);
         chk($sformatf("%s_rdy_t%0d", name, t), in_ready, 1'b1);
         if (idx >= 0 && idx < n) begin
            chk($sformatf("%s_vld%0d", name, idx), wb_valid, 1'b1);
            chk($sformatf("%s_data%0d", name, idx), wb_data, qexp[idx]);
            chk($sformatf("%s_rd%0d", name, idx), wb_rd_id, qrd[idx]);
         end else begin
            chk($sformatf("%s_idle_t%0d", name, t), wb_valid, 1'b0);
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_rd_id = '0;
      in_ra    = '0;
      in_rb    = '0;
      flush    = 1'b0;
      wb_ready = 1'b1;
      #1;
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_wb_rd", wb_rd_id, 5'd0);
      chk("rst_mask", pending_mask, 32'h0);
      chk("rst_in_ready", in_ready, 1'b1);
      #11 rst_n = 1'b1;
      step();

      // Single op
      set_op(0, 32'd7, 32'd6, 5'd5, 32'd42);
      run_seq("single", 1);

      // Wrap / overflow and cross-term coverage
      set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001);
      set_op(1, 32'h8000_0000, 32'h0000_0002, 5'd2, 32'h0000_0000);
      set_op(2, 32'h0001_0000, 32'h0001_0000, 5'd3, 32'h0000_0000);
      set_op(3, 32'h0000_FFFF, 32'h0000_FFFF, 5'd4, 32'hFFFE_0001);
      set_op(4, 32'h0001_0003, 32'h0002_0005, 5'd6, 32'h000B_000F);
      run_seq("wrap", 5);

      // Back-to-back i*(i+1), rd=i
      set_op(0, 32'd0, 32'd1, 5'd0, 32'd0);
      set_op(1, 32'd1, 32'd2, 5'd1, 32'd2);
      set_op(2, 32'd2, 32'd3, 5'd2, 32'd6);
      set_op(3, 32'd3, 32'd4, 5'd3, 32'd12);
      set_op(4, 32'd4, 32'd5, 5'd4, 32'd20);
      set_op(5, 32'd5, 32'd6, 5'd5, 32'd30);
      set_op(6, 32'd6, 32'd7, 5'd6, 32'd42);
      set_op(7, 32'd7, 32'd8, 5'd7, 32'd56);
      run_seq("b2b", 8);

      // Back-pressure: fill, stall 3 cycles with a stray in_valid, then drain
      set_op(0, 32'd2, 32'd3, 5'd10, 32'd6);
      set_op(1, 32'd3, 32'd3, 5'd11, 32'd9);
      set_op(2, 32'd4, 32'd3, 5'd12, 32'd12);
      set_op(3, 32'd5, 32'd3, 5'd13, 32'd15);
      for (int t = 0; t < 4; t++) begin
         drive_op(t);
         step();
      end
      in_valid = 1'b0;
      chk("bp_full_vld", wb_valid, 1'b1);
      chk("bp_full_data", wb_data, 32'd6);
      wb_ready = 1'b0;
      in_valid = 1'b1;
      in_ra    = 32'd100;
      in_rb    = 32'd100;
      in_rd_id = 5'd20;
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("bp_hold_vld%0d", c), wb_valid, 1'b1);
         chk($sformatf("bp_hold_data%0d", c), wb_data, 32'd6);
         chk($sformatf("bp_hold_rd%0d", c), wb_rd_id, 5'd10);
         chk($sformatf("bp_hold_rdy%0d", c), in_ready, 1'b0);
         chk($sformatf("bp_hold_mask%0d", c), pending_mask, 32'h0000_3C00);
      end
      wb_ready = 1'b1;
      in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         step();
         chk($sformatf("bp_drain_vld%0d", k), wb_valid, 1'b1);
         chk($sformatf("bp_drain_data%0d", k), wb_data, qexp[k]);
         chk($sformatf("bp_drain_rd%0d", k), wb_rd_id, qrd[k]);
      end
      step();
      chk("bp_done_vld", wb_valid, 1'b0);
      chk("bp_done_mask", pending_mask, 32'h0);

      // Flush with 3 in flight plus an input in the flush cycle
      set_op(0, 32'd3, 32'd3, 5'd1, 32'd9);
      set_op(1, 32'd3, 32'd4, 5'd2, 32'd12);
      set_op(2, 32'd3, 32'd5, 5'd3, 32'd15);
      for (int t = 0; t < 3; t++) begin
         drive_op(t);
         step();
      end
      in_valid = 1'b1;
      in_ra    = 32'd8;
      in_rb    = 32'd8;
      in_rd_id = 5'd9;
      flush    = 1'b1;
      #1;
      chk("fl_in_ready", in_ready, 1'b1);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_mask", pending_mask, 32'h0);
      chk("fl_vld", wb_valid, 1'b0);
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("fl_quiet%0d", c), wb_valid, 1'b0);
      end

      // Asynchronous reset with 2 ops in flight, first already at the output
      set_op(0, 32'd11, 32'd2, 5'd14, 32'd22);
      set_op(1, 32'd11, 32'd3, 5'd15, 32'd33);
      for (int t = 0; t < 2; t++) begin
         drive_op(t);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      chk("ar_pre_vld", wb_valid, 1'b1);
      chk("ar_pre_data", wb_data, 32'd22);
      chk("ar_pre_mask", pending_mask, 32'h0000_C000);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_vld", wb_valid, 1'b0);
      chk("ar_data", wb_data, 32'h0);
      chk("ar_rd", wb_rd_id, 5'd0);
      chk("ar_mask", pending_mask, 32'h0);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("ar_quiet%0d", c), wb_valid, 1'b0);
      end
      set_op(0, 32'd9, 32'd9, 5'd7, 32'd81);
      run_seq("post_rst", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
